// File: rtl/debug_pkg.sv
`default_nettype none
// ============================================================================
// Package  : debug_pkg
// Purpose  : Shared definitions for the CPU debug display path. Contains the
//            display word type and the key level encoding. It also holds the
//            default debounce and blank times for the board clock.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package debug_pkg;

  // Six hex digits, one nibble each.
  localparam int DISPLAY_W = 24;
  typedef logic [DISPLAY_W-1:0] disp_word_t;

  // Defaults for the board clock: 10 ms debounce and 50 ms blank at 50 MHz.
  localparam int DEF_DEBOUNCE_CYCLES = 500000;
  localparam int DEF_BLANK_CYCLES    = 2500000;

  // Push-buttons are active-low, so the idle (released) level is 1.
  typedef enum logic {
    KEY_PRESSED  = 1'b0,
    KEY_RELEASED = 1'b1
  } key_level_t;

endpackage : debug_pkg
`default_nettype wire

// File: rtl/key_debounce.sv
`default_nettype none
// ============================================================================
// Module   : key_debounce
// Purpose  : Handles one active-low push-button. The raw input passes through
//            a 2-FF synchroniser and is then debounced. A one-cycle press
//            pulse is emitted when the debounced level goes from released to
//            pressed.
// Ports    : clk    in  1  system clock
//            reset  in  1  synchronous, active-high reset
//            key_n  in  1  raw active-low key (asynchronous, bouncy)
//            press  out 1  one-cycle pulse per accepted press
// Revision : 1.0 - initial release
// ============================================================================
module key_debounce
  import debug_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES
) (
  input  logic clk,
  input  logic reset,
  input  logic key_n,
  output logic press
);

  localparam int               CNT_W    = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic             sync_meta;
  logic             sync_key;
  key_level_t       stable;
  logic [CNT_W-1:0] cnt;

  // Sync FFs reset to the released level. A key that is still held when
  // reset is released therefore looks like a fresh press and gets a full
  // debounce.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync_meta <= 1'b1;
      sync_key  <= 1'b1;
      stable    <= KEY_RELEASED;
      cnt       <= '0;
      press     <= 1'b0;
    end else begin
      sync_meta <= key_n;
      sync_key  <= sync_meta;
      press     <= 1'b0;
      if (sync_key == logic'(stable)) begin
        // Any bounce back to the accepted level restarts the qualification.
        cnt <= '0;
      end else if (cnt == CNT_LAST) begin
        // This is the DEBOUNCE_CYCLES-th consecutive cycle at the new level.
        cnt    <= '0;
        stable <= key_level_t'(sync_key);
        press  <= (sync_key == logic'(KEY_PRESSED));
      end else begin
        cnt <= cnt + CNT_ONE;
      end
    end
  end

endmodule : key_debounce
`default_nettype wire

// File: rtl/hex_display_pager.sv
`default_nettype none
// ============================================================================
// Module   : hex_display_pager
// Purpose  : Registered source for the six-digit hex display driver. It
//            selects one of NUM_PAGES debug words. A debounced key steps
//            through the pages. Freeze holds the shown word. The display is
//            blanked for BLANK_CYCLES after each page change.
// Ports    : clk         in  1                system clock
//            reset       in  1                synchronous, active-high reset
//            enable      in  1                display enable (debug switch)
//            key_next_n  in  1                raw active-low page-step key
//            freeze      in  1                1 = hold displayed value
//            page_data   in  NUM_PAGES x 24   packed debug words
//            value       out 24               word to display driver
//            debug_en    out 1                display enable to driver
//            page        out PAGE_W           selected page index
// Revision : 1.0 - initial release
// ============================================================================
module hex_display_pager
  import debug_pkg::*;
#(
  parameter int NUM_PAGES       = 4,
  parameter int PAGE_W          = $clog2(NUM_PAGES),
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int BLANK_CYCLES    = DEF_BLANK_CYCLES
) (
  input  logic                                clk,
  input  logic                                reset,
  input  logic                                enable,
  input  logic                                key_next_n,
  input  logic                                freeze,
  input  logic [NUM_PAGES-1:0][DISPLAY_W-1:0] page_data,
  output disp_word_t                          value,
  output logic                                debug_en,
  output logic [PAGE_W-1:0]                   page
);

  // Keep at least one bit so that BLANK_CYCLES = 0 still elaborates.
  localparam int BLANK_W = (BLANK_CYCLES > 0) ? $clog2(BLANK_CYCLES + 1) : 1;

  localparam logic [BLANK_W-1:0] BLANK_LOAD = BLANK_W'(BLANK_CYCLES);
  localparam logic [BLANK_W-1:0] BLANK_ONE  = BLANK_W'(1);
  localparam logic [PAGE_W-1:0]  PAGE_LAST  = PAGE_W'(NUM_PAGES - 1);
  localparam logic [PAGE_W-1:0]  PAGE_ONE   = PAGE_W'(1);

  logic               press;
  logic [BLANK_W-1:0] blank_cnt;
  disp_word_t         page_word;

  key_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_key_next (
    .clk  (clk),
    .reset(reset),
    .key_n(key_next_n),
    .press(press)
  );

  // Explicit compare-and-select mux. Page codes at or above NUM_PAGES fall
  // through to zero, so value can never pick up X from an unmatched index.
  always_comb begin
    page_word = '0;
    for (int i = 0; i < NUM_PAGES; i++) begin
      if (page == i[PAGE_W-1:0]) begin
        page_word = page_data[i];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      page      <= '0;
      blank_cnt <= '0;
      value     <= '0;
      debug_en  <= 1'b0;
    end else begin
      if (press) begin
        page      <= (page == PAGE_LAST) ? '0 : page + PAGE_ONE;
        // Reload, not accumulate: a press during a blank restarts the blank.
        blank_cnt <= BLANK_LOAD;
      end else if (blank_cnt != '0) begin
        blank_cnt <= blank_cnt - BLANK_ONE;
      end

      // Uses the page before any step in this cycle, so a step together
      // with a freeze rise holds the word from before the step.
      if (!freeze) begin
        value <= page_word;
      end

      debug_en <= enable && (blank_cnt == '0);
    end
  end

endmodule : hex_display_pager
`default_nettype wire

// File: tb/tb_hex_display_pager.sv
`default_nettype none
// ============================================================================
// Module   : tb_hex_display_pager
// Purpose  : Self-checking bench for hex_display_pager. Uses NUM_PAGES=3,
//            DEBOUNCE_CYCLES=4 and BLANK_CYCLES=3.
// Revision : 1.0 - initial release
// ============================================================================
module tb_hex_display_pager;

  localparam int NP  = 3;
  localparam int DB  = 4;
  localparam int BLK = 3;

  logic                 clk = 1'b0;
  logic                 reset;
  logic                 enable;
  logic                 key_next_n;
  logic                 freeze;
  logic [NP-1:0][23:0]  page_data;
  logic [23:0]          value;
  logic                 debug_en;
  logic [1:0]           page;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model state
  int          m_page;
  int          m_blank;
  logic [23:0] m_value;
  bit          m_den;
  bit          m_stable;   // accepted key level, 1 = released
  bit          m_press;    // press accepted last cycle, acts this cycle
  bit          key_q[$];   // raw samples still inside the synchroniser
  bit          deb_hist[$];// last DB levels seen by the debouncer

  always #5 clk = ~clk;

  hex_display_pager #(
    .NUM_PAGES      (NP),
    .PAGE_W         (2),
    .DEBOUNCE_CYCLES(DB),
    .BLANK_CYCLES   (BLK)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .enable    (enable),
    .key_next_n(key_next_n),
    .freeze    (freeze),
    .page_data (page_data),
    .value     (value),
    .debug_en  (debug_en),
    .page      (page)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Advance one clock. The model computes the next state from the inputs
  // held at the edge. The DUT outputs are then compared 1 ns after the edge.
  task automatic tick();
    bit          deb_in;
    bit          all_diff;
    int          n_page, n_blank;
    logic [23:0] n_value;
    bit          n_den, n_stable, n_press;
    if (reset) begin
      n_page = 0; n_blank = 0; n_value = '0; n_den = 0;
      n_stable = 1; n_press = 0;
      key_q = {1'b1, 1'b1};
      deb_hist.delete();
      for (int i = 0; i < DB; i++) deb_hist.push_back(1'b1);
    end else begin
      // Two-stage synchroniser: the debouncer sees the key from two edges ago.
      deb_in = key_q.pop_front();
      key_q.push_back(key_next_n);
      void'(deb_hist.pop_front());
      deb_hist.push_back(deb_in);
      // A level change is accepted once the last DB samples all disagree
      // with the accepted level.
      all_diff = 1;
      foreach (deb_hist[i]) if (deb_hist[i] == m_stable) all_diff = 0;
      n_stable = all_diff ? deb_in : m_stable;
      n_press  = all_diff && (deb_in == 1'b0);
      if (m_press) begin
        n_page  = (m_page + 1) % NP;
        n_blank = BLK;
      end else begin
        n_page  = m_page;
        n_blank = (m_blank > 0) ? m_blank - 1 : 0;
      end
      n_value = freeze ? m_value : page_data[m_page];
      n_den   = enable && (m_blank == 0);
    end
    @(posedge clk);
    #1;
    m_page = n_page; m_blank = n_blank; m_value = n_value; m_den = n_den;
    m_stable = n_stable; m_press = n_press;
    check("value", 32'(value), 32'(m_value));
    check("page", 32'(page), 32'(m_page));
    check("debug_en", 32'(debug_en), 32'(m_den));
  endtask

  task automatic hold_key(input bit lvl, input int n);
    key_next_n = lvl;
    for (int i = 0; i < n; i++) tick();
  endtask

  initial begin
    int low_cnt;
    int waited;
    reset      = 1'b1;
    enable     = 1'b1;
    key_next_n = 1'b1;
    freeze     = 1'b0;
    page_data  = {24'h333333, 24'h222222, 24'h111111};

    // Reset state
    tick(); tick();
    check("rst_value", 32'(value), 32'h0);
    check("rst_den", 32'(debug_en), 32'h0);
    check("rst_page", 32'(page), 32'h0);
    reset = 1'b0;
    tick();
    check("first_value", 32'(value), 32'h111111);
    check("first_page", 32'(page), 32'h0);
    check("first_den", 32'(debug_en), 32'h1);

    // Clean press held for 10 cycles: exactly one step and a 3-cycle blank.
    low_cnt = 0;
    key_next_n = 1'b0;
    for (int i = 0; i < 10; i++) begin tick(); if (!debug_en) low_cnt++; end
    key_next_n = 1'b1;
    for (int i = 0; i < 10; i++) begin tick(); if (!debug_en) low_cnt++; end
    check("clean_page", 32'(page), 32'h1);
    check("clean_value", 32'(value), 32'h222222);
    check("blank_len", 32'(low_cnt), 32'd3);

    // Bouncy press: toggling every 2 cycles must not qualify, the hold must.
    for (int i = 0; i < 6; i++) hold_key(i[0], 2);
    hold_key(1'b0, 10);
    hold_key(1'b1, 10);
    check("bouncy_page", 32'(page), 32'h2);

    // Wrap: three presses from page 2 give pages 0, 1, 2.
    for (int i = 0; i < 3; i++) begin
      hold_key(1'b0, 10);
      hold_key(1'b1, 10);
      check("wrap_page", 32'(page), 32'(i));
    end

    // Return to page 0, then test freeze.
    hold_key(1'b0, 10);
    hold_key(1'b1, 10);
    freeze = 1'b1;
    tick();
    page_data[0] = 24'hABCDEF;
    hold_key(1'b0, 10);
    hold_key(1'b1, 10);
    check("frz_value", 32'(value), 32'h111111);
    check("frz_page", 32'(page), 32'h1);
    freeze = 1'b0;
    tick();
    check("unfrz_value", 32'(value), 32'h222222);

    // Enable low forces the display off.
    enable = 1'b0;
    tick(); tick();
    check("en_off", 32'(debug_en), 32'h0);
    enable = 1'b1;
    tick();

    // Reset during blank with the key still held.
    key_next_n = 1'b0;
    waited = 0;
    while (m_blank == 0 && waited < 20) begin tick(); waited++; end
    check("blank_reached", 32'(m_blank != 0), 32'h1);
    reset = 1'b1;
    tick();
    check("rb_page", 32'(page), 32'h0);
    check("rb_den", 32'(debug_en), 32'h0);
    reset = 1'b0;
    hold_key(1'b0, 12);
    check("rb_step", 32'(page), 32'h1);
    hold_key(1'b1, 10);

    // Randomized phase
    for (int r = 0; r < 80; r++) begin
      if ($urandom_range(0, 7) == 0) freeze = ~freeze;
      enable = ($urandom_range(0, 9) != 0);
      if ($urandom_range(0, 3) == 0) page_data[$urandom_range(0, NP-1)] = 24'($urandom);
      if ($urandom_range(0, 40) == 0) begin
        reset = 1'b1; tick(); reset = 1'b0;
      end
      hold_key(1'($urandom_range(0, 1)), $urandom_range(1, 8));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule : tb_hex_display_pager
`default_nettype wire
